// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one SRAM-like request/response port between the
// instruction fetch requester and the data requester.
//
// Handshake rules (valid/ready style, used on every request channel):
//   - A request is offered by holding *_req high with stable fields.
//   - It transfers in the cycle where mem_req && mem_addr_ok are both high;
//     the winning requester sees its *_addr_ok pulse in that same cycle.
//   - Responses are not back-pressured: each mem_data_ok pulse answers the
//     oldest accepted request, in order.
//
// The data requester has fixed priority, but grants are non-preemptive:
// once a request is offered and not yet accepted, the arbiter locks onto
// that owner until it is accepted or withdrawn (pipeline flush).
// An in-order ID FIFO remembers the owner of each accepted request so that
// responses are steered back. Request and response paths are combinational.
module mem_req_arbiter #(
    parameter int OUTSTANDING = 2,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [31:0]       inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [31:0]       mem_rdata,
    output logic [1:0]        dbg_state
);

    localparam int CNT_W = $clog2(OUTSTANDING + 1);
    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_I = 2'd1,
        LOCK_D = 2'd2
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       count;
    logic [PTR_W-1:0]       rd_ptr;
    logic [PTR_W-1:0]       wr_ptr;
    logic [OUTSTANDING-1:0] id_fifo;   // 0 = inst, 1 = data

    logic sel_i;
    logic sel_d;
    logic full;
    logic empty;
    logic accept;
    logic pop;
    logic head_id;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Full is judged on the registered count only, so a same-cycle response
    // never opens a slot for a same-cycle grant (no mem_data_ok -> mem_req path).
    assign full  = (count == CNT_W'(OUTSTANDING));
    assign empty = (count == '0);

    // Pick the grantee: the locked owner, else data over inst when a slot is free.
    always_comb begin
        sel_i = 1'b0;
        sel_d = 1'b0;
        case (state)
            LOCK_I:  sel_i = 1'b1;
            LOCK_D:  sel_d = 1'b1;
            default: begin
                if (!full) begin
                    if (data_req) begin
                        sel_d = 1'b1;
                    end else if (inst_req) begin
                        sel_i = 1'b1;
                    end
                end
            end
        endcase
    end

    // Steer the grantee's fields onto the memory port; fetches never write.
    always_comb begin
        mem_req   = (sel_d && data_req) || (sel_i && inst_req);
        mem_wr    = 1'b0;
        mem_wstrb = 4'h0;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        if (sel_d) begin
            mem_wr    = data_wr;
            mem_wstrb = data_wstrb;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end else if (sel_i) begin
            mem_addr  = inst_addr;
        end
    end

    assign accept       = mem_req && mem_addr_ok;
    assign inst_addr_ok = accept && sel_i;
    assign data_addr_ok = accept && sel_d;

    // A response with nothing outstanding is a protocol error and is dropped.
    assign pop          = mem_data_ok && !empty;
    assign head_id      = id_fifo[rd_ptr];
    assign inst_data_ok = pop && !head_id;
    assign data_data_ok = pop && head_id;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    assign dbg_state    = state;

    // Grant lock FSM: hold an offered-but-unaccepted request until accepted or withdrawn.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_d && !mem_addr_ok) begin
                        state <= LOCK_D;
                    end else if (sel_i && !mem_addr_ok) begin
                        state <= LOCK_I;
                    end
                end
                LOCK_I: begin
                    if (!inst_req || mem_addr_ok) begin
                        state <= IDLE;
                    end
                end
                LOCK_D: begin
                    if (!data_req || mem_addr_ok) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ID FIFO: push owner on acceptance, pop head on each valid response.
    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            id_fifo <= '0;
        end else begin
            if (accept) begin
                id_fifo[wr_ptr] <= sel_d;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed scenarios plus randomized traffic. A
// transaction-level model (owner queue + current lock owner) predicts each
// cycle's grant; accepted requests push their owner into a scoreboard queue
// that an independent monitor pops whenever the slave returns a response.
module tb_mem_req_arbiter;

    localparam int OUTSTANDING = 2;
    localparam int ADDR_W      = 32;

    logic              clk;
    logic              reset;
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [31:0]       inst_rdata;
    logic              data_req;
    logic              data_wr;
    logic [3:0]        data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;
    logic              mem_req;
    logic              mem_wr;
    logic [3:0]        mem_wstrb;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_addr_ok;
    logic              mem_data_ok;
    logic [31:0]       mem_rdata;
    logic [1:0]        dbg_state;

    mem_req_arbiter #(.OUTSTANDING(OUTSTANDING), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    logic [0:0] exp_q[$];       // owner of each accepted, unanswered request (1 = data)
    int         lock_owner;     // 0 none, 1 inst, 2 data: offered but not accepted
    int         n_cmp;
    int         n_fail;
    logic       last_acc_i;
    logic       last_acc_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- response monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (mem_data_ok && exp_q.size() > 0) begin
                    logic [0:0] owner;
                    owner = exp_q.pop_front();
                    chk("inst_data_ok", {31'b0, inst_data_ok}, {31'b0, owner == 1'b0});
                    chk("data_data_ok", {31'b0, data_data_ok}, {31'b0, owner == 1'b1});
                    chk("inst_rdata", inst_rdata, mem_rdata);
                    chk("data_rdata", data_rdata, mem_rdata);
                end else begin
                    chk("no_inst_data_ok", {31'b0, inst_data_ok}, 32'h0);
                    chk("no_data_data_ok", {31'b0, data_data_ok}, 32'h0);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [3:0] ds, input logic [31:0] da, input logic [31:0] dd);
        inst_req   = ir;
        inst_addr  = ia;
        data_req   = dr;
        data_wr    = dw;
        data_wstrb = ds;
        data_addr  = da;
        data_wdata = dd;
    endtask

    // One bus cycle: drive at posedge+1, predict the grant, check at posedge+6.
    task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                        input logic [3:0] ds, input logic [31:0] da, input logic [31:0] dd,
                        input logic aok, input logic dok, input logic [31:0] rd);
        int   g;
        logic req_exp;
        @(posedge clk);
        #1;
        drive(ir, ia, dr, dw, ds, da, dd);
        mem_addr_ok = aok;
        mem_data_ok = dok;
        mem_rdata   = rd;
        if (lock_owner != 0)                 g = lock_owner;
        else if (exp_q.size() >= OUTSTANDING) g = 0;
        else if (dr)                          g = 2;
        else if (ir)                          g = 1;
        else                                  g = 0;
        req_exp = (g == 1 && ir) || (g == 2 && dr);
        #5;
        chk("mem_req", {31'b0, mem_req}, {31'b0, req_exp});
        if (req_exp) begin
            chk("mem_addr", mem_addr, (g == 2) ? da : ia);
            chk("mem_wr", {31'b0, mem_wr}, {31'b0, (g == 2) ? dw : 1'b0});
            chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, (g == 2) ? ds : 4'h0});
            chk("mem_wdata", mem_wdata, (g == 2) ? dd : 32'h0);
        end
        last_acc_i = (g == 1) && req_exp && aok;
        last_acc_d = (g == 2) && req_exp && aok;
        chk("inst_addr_ok", {31'b0, inst_addr_ok}, {31'b0, last_acc_i});
        chk("data_addr_ok", {31'b0, data_addr_ok}, {31'b0, last_acc_d});
        if (last_acc_i) exp_q.push_back(1'b0);
        if (last_acc_d) exp_q.push_back(1'b1);
        if (lock_owner != 0) begin
            if (!req_exp || aok) lock_owner = 0;
        end else if (g != 0 && !aok) begin
            lock_owner = g;
        end
    endtask

    task automatic idle_step(input logic dok, input logic [31:0] rd);
        step(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, dok, rd);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        lock_owner = 0;
        #5;
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_inst_addr_ok", {31'b0, inst_addr_ok}, 32'h0);
        chk("rst_data_addr_ok", {31'b0, data_addr_ok}, 32'h0);
        chk("rst_inst_data_ok", {31'b0, inst_data_ok}, 32'h0);
        chk("rst_data_data_ok", {31'b0, data_data_ok}, 32'h0);
    endtask

    // ---------------- stimulus ----------------
    logic        ipend;
    logic        dpend;
    logic [31:0] r_ia;
    logic [31:0] r_da;
    logic [31:0] r_dd;
    logic        r_dw;
    logic [3:0]  r_ds;

    initial begin
        n_cmp = 0;
        n_fail = 0;
        lock_owner = 0;
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        do_reset();

        // Single fetch, response two cycles after acceptance.
        step(1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        idle_step(1'b0, 32'h0);
        idle_step(1'b1, 32'h3C1D_0001);

        // Same-cycle conflict: data store wins, fetch follows; responses in order.
        step(1'b1, 32'hBFC0_0000, 1'b1, 1'b1, 4'hF, 32'h8000_1000, 32'h1234_5678, 1'b1, 1'b0, 32'h0);
        step(1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        idle_step(1'b1, 32'hAAAA_0001);
        idle_step(1'b1, 32'hBBBB_0002);

        // Lock hold: fetch stalls three cycles while a load waits behind it.
        step(1'b1, 32'hBFC0_0004, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'hBFC0_0004, 1'b1, 1'b0, 4'h0, 32'h8000_2000, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'hBFC0_0004, 1'b1, 1'b0, 4'h0, 32'h8000_2000, 32'h0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'hBFC0_0004, 1'b1, 1'b0, 4'h0, 32'h8000_2000, 32'h0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8000_2000, 32'h0, 1'b1, 1'b0, 32'h0);
        idle_step(1'b1, 32'h1111_0000);
        idle_step(1'b1, 32'h2222_0000);

        // Full FIFO: two loads outstanding, third blocked even with a same-cycle response.
        step(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8000_3000, 32'h0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8000_3004, 32'h0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8000_3008, 32'h0, 1'b1, 1'b1, 32'h3333_0000);
        step(1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h8000_3008, 32'h0, 1'b1, 1'b0, 32'h0);

        // Reset with two outstanding, then a stray response must be ignored.
        do_reset();
        idle_step(1'b1, 32'hDEAD_BEEF);
        idle_step(1'b1, 32'hDEAD_BEEF);

        // Steady stream: accept and respond every cycle, alternating owners.
        for (int k = 0; k < 8; k++) begin
            step(k % 2 == 0, 32'hBFC0_1000 + 32'(k * 4), k % 2 == 1, 1'b0, 4'h0,
                 32'h8000_4000 + 32'(k * 4), 32'h0, 1'b1, k > 0, $urandom());
        end
        idle_step(1'b1, $urandom());

        // Randomized traffic with occasional flush-style withdrawals.
        ipend = 1'b0;
        dpend = 1'b0;
        r_ia = 32'h0; r_da = 32'h0; r_dd = 32'h0; r_dw = 1'b0; r_ds = 4'h0;
        for (int c = 0; c < 600; c++) begin
            logic aok;
            logic dok;
            if (!ipend && $urandom_range(0, 2) == 0) begin
                ipend = 1'b1;
                r_ia  = $urandom() & 32'hFFFF_FFFC;
            end
            if (!dpend && $urandom_range(0, 2) == 0) begin
                dpend = 1'b1;
                r_da  = $urandom() & 32'hFFFF_FFFC;
                r_dd  = $urandom();
                r_dw  = 1'($urandom_range(0, 1));
                r_ds  = r_dw ? 4'($urandom_range(1, 15)) : 4'h0;
            end
            if (ipend && $urandom_range(0, 49) == 0) ipend = 1'b0;
            if (dpend && $urandom_range(0, 49) == 0) dpend = 1'b0;
            aok = ($urandom_range(0, 2) != 0);
            dok = (exp_q.size() > 0) && ($urandom_range(0, 1) == 1);
            step(ipend, r_ia, dpend, r_dw, r_ds, r_da, r_dd, aok, dok, $urandom());
            if (last_acc_i) ipend = 1'b0;
            if (last_acc_d) dpend = 1'b0;
        end

        // Drain remaining responses within a bounded number of cycles.
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            idle_step(1'b1, $urandom());
        end
        chk("drain_empty", 32'(exp_q.size()), 32'h0);

        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction fetch requester (IF stage) and the data requester (EXE/MEM stage).
- Fixed priority goes to the data requester. A granted request is held until the slave accepts it.
- An in-order ID FIFO records the owner of each accepted request, so each response is steered back to the requester that issued it.
- Sits between the pipeline stages and the AXI/SRAM bridge.

Parameters:
OUTSTANDING, 2, max accepted-but-unanswered requests (ID FIFO depth, >=1)
ADDR_W, 32, address width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
inst_req  in  1  fetch request valid
inst_addr  in  ADDR_W  fetch address
inst_addr_ok  out  1  fetch request accepted this cycle
inst_data_ok  out  1  fetch response valid
inst_rdata  out  32  fetch read data
data_req  in  1  data request valid
data_wr  in  1  1=store, 0=load
data_wstrb  in  4  store byte strobes
data_addr  in  ADDR_W  data address
data_wdata  in  32  store data
data_addr_ok  out  1  data request accepted this cycle
data_data_ok  out  1  data response valid (load data or store ack)
data_rdata  out  32  load data
mem_req  out  1  request to slave
mem_wr  out  1  write flag to slave
mem_wstrb  out  4  strobes to slave (4'h0 for fetch)
mem_addr  out  ADDR_W  address to slave
mem_wdata  out  32  write data to slave (0 for fetch)
mem_addr_ok  in  1  slave accepted request
mem_data_ok  in  1  slave response valid
mem_rdata  in  32  slave read data

Behaviour:
- Reset: state IDLE; FIFO empty (count=0, rd/wr pointers 0). mem_req, inst_addr_ok, data_addr_ok, inst_data_ok and data_data_ok all 0.
- Request handshake: a request is transferred on mem_req && mem_addr_ok. The requester keeps its request and fields stable until it sees addr_ok.
- FSM states:
  - IDLE: no request is pending.
  - LOCK_I: an issued fetch request has not yet been accepted.
  - LOCK_D: an issued data request has not yet been accepted.
- IDLE behaviour:
  - If the FIFO is full, mem_req=0 and no grant is made.
  - Otherwise, if data_req is high, the data requester drives the mem_* fields combinationally. If mem_addr_ok is also high, the request is accepted the same cycle (data_addr_ok=1) and the FSM stays in IDLE; if not, the next state is LOCK_D.
  - Otherwise, if inst_req is high, the same applies to the fetch requester, with LOCK_I as the lock state.
- LOCK_x behaviour:
  - mem_* fields come only from owner x. mem_req = x_req.
  - The other requester is ignored, even a data request arriving while in LOCK_I. Grants are non-preemptive.
  - Return to IDLE on acceptance (x_addr_ok=1). Also return to IDLE if x drops its request, which is legal only on a pipeline flush.
- addr_ok routing: x_addr_ok = mem_addr_ok && mem_req && (grantee == x). It is never asserted for the non-grantee.
- ID FIFO push: on acceptance, push the owner ID (0=inst, 1=data).
- ID FIFO pop: on mem_data_ok, pop the head. Route the response to the head ID:
  - inst_data_ok/data_data_ok = mem_data_ok && head matches that requester.
  - inst_rdata and data_rdata both equal mem_rdata unconditionally; only the *_data_ok flags are steered.
- Latency: zero-cycle combinational pass-through for both request and response; no added pipeline stage.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full FIFO (count==OUTSTANDING): no new grant.
  - A same-cycle pop does NOT free a slot for a same-cycle grant. The grant decision uses the registered count only, which avoids a combinational path from mem_data_ok to mem_req.
- mem_data_ok with an empty FIFO is a protocol error: no *_data_ok is asserted and the count stays 0.
- Pointers wrap modulo OUTSTANDING. Count width is clog2(OUTSTANDING+1).
- Reset mid-transaction:
  - The FIFO and FSM are cleared. Responses still in flight from the slave are discarded under the empty-FIFO rule.
  - The slave is reset by the same reset signal.

Test Plan:
- Single fetch: inst_req=1, inst_addr=0xBFC00000, slave addr_ok the same cycle and data_ok 2 cycles later with rdata=0x3C1D0001 -> inst_addr_ok pulses once; 2 cycles later inst_data_ok=1 with inst_rdata=0x3C1D0001; data_data_ok stays 0.
- Same-cycle conflict: inst_req=1 and data_req=1 (store, addr=0x80001000, wstrb=4'hF, wdata=0x12345678), addr_ok=1 -> data granted first with mem_wr=1 and mem_wstrb=4'hF; fetch granted the next cycle; responses return in order data then inst.
- Lock hold: fetch issued with mem_addr_ok held 0 for 3 cycles while data_req rises in cycle 1 -> mem_addr stays 0xBFC00004 throughout; data granted only after inst_addr_ok.
- Full FIFO (OUTSTANDING=2): two accepted loads with no data_ok -> third request sees mem_req=0. When data_ok and a new request coincide, the new request is accepted the cycle after.
- Push+pop same cycle: a steady stream with addr_ok and data_ok every cycle -> count constant at 1; IDs alternate correctly over 8 mixed inst/data requests.
- Reset mid-flight: reset asserted with count=2 -> all outputs 0 the next cycle; a stray mem_data_ok after reset yields no *_data_ok.
